// File: rtl/my_ep_tx_cpl_engine.sv
// ---------------------------------------------------------------------------
// my_ep_tx_cpl_engine
//
// Transmit half of the endpoint memory controller's completion path. A single
// outstanding completion request is latched. One DW is read from BAR memory
// and a Cpl (3 DW) or CplD (4 DW) TLP is sent on the 32-bit TRN TX interface.
// compl_done_o pulses for one cycle once the last beat has been accepted.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_compl_i            1-cycle request strobe (honoured only when idle)
//   req_compl_with_data_i  1 = CplD, 0 = Cpl
//   req_tc/td/ep/attr_i    echoed into DW0
//   req_len_i              request length (only 1 DW is ever returned)
//   req_rid_i, req_tag_i   echoed into DW2
//   req_be_i               [3:0] first-DW byte enables, [7:4] unused
//   req_addr_i             request byte address
//   completer_id_i         {bus,dev,func} placed into DW1
//   compl_done_o           completion sent
//   rd_addr_o, rd_be_o     BAR memory read address / byte enables
//   rd_data_i              BAR memory read data, 1-cycle latency
//   trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n   TX beat outputs
//   trn_tdst_rdy_n, trn_tdst_dsc_n, trn_tbuf_av      TX core status
// ---------------------------------------------------------------------------
module my_ep_tx_cpl_engine #(
    parameter int ADDR_W   = 11,
    parameter int TBUF_MIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_compl_i,
    input  logic              req_compl_with_data_i,
    input  logic [2:0]        req_tc_i,
    input  logic              req_td_i,
    input  logic              req_ep_i,
    input  logic [1:0]        req_attr_i,
    input  logic [9:0]        req_len_i,
    input  logic [15:0]       req_rid_i,
    input  logic [7:0]        req_tag_i,
    input  logic [7:0]        req_be_i,
    input  logic [12:0]       req_addr_i,
    input  logic [15:0]       completer_id_i,
    output logic              compl_done_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [3:0]        rd_be_o,
    input  logic [31:0]       rd_data_i,
    output logic [31:0]       trn_td,
    output logic              trn_tsof_n,
    output logic              trn_teof_n,
    output logic              trn_tsrc_rdy_n,
    input  logic              trn_tdst_rdy_n,
    input  logic              trn_tdst_dsc_n,
    input  logic [5:0]        trn_tbuf_av
);

    localparam logic [5:0] TBUF_MIN_L = 6'(TBUF_MIN);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BUF, S_DW0, S_DW1, S_DW2, S_DW3, S_DONE
    } state_t;

    state_t state, state_nxt;

    // Latched request fields (BE lives in rd_be_o, which is held anyway).
    logic        wd_q;
    logic [2:0]  tc_q;
    logic        td_q;
    logic        ep_q;
    logic [1:0]  attr_q;
    logic [15:0] rid_q;
    logic [7:0]  tag_q;
    logic [4:0]  la_q;      // req_addr[6:2]

    // Next values for the registered outputs.
    logic [31:0] td_nxt;
    logic        sof_n_nxt;
    logic        eof_n_nxt;
    logic        rdy_n_nxt;
    logic        done_nxt;
    logic        load_req;

    logic        beat_ok;
    logic [11:0] byte_cnt;
    logic [1:0]  lo2;
    logic [31:0] dw0, dw1, dw2, dw3;

    // Length is always 1 DW; the low address bits only matter through BE.
    logic unused_ok;
    assign unused_ok = ^{req_len_i, req_be_i[7:4], req_addr_i[1:0]};

    assign beat_ok = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;

    // Byte count spans from the lowest to the highest enabled byte; a Cpl
    // without data and an all-zero BE both report 1.
    always_comb begin
        byte_cnt = 12'd1;
        if (wd_q) begin
            casez (rd_be_o)
                4'b1??1:                    byte_cnt = 12'd4;
                4'b01?1, 4'b1?10:           byte_cnt = 12'd3;
                4'b0011, 4'b0110, 4'b1100:  byte_cnt = 12'd2;
                default:                    byte_cnt = 12'd1;
            endcase
        end
    end

    // Lower address bits [1:0] come from the first enabled byte.
    always_comb begin
        casez (rd_be_o)
            4'b???1: lo2 = 2'd0;
            4'b??10: lo2 = 2'd1;
            4'b?100: lo2 = 2'd2;
            4'b1000: lo2 = 2'd3;
            default: lo2 = 2'd0;
        endcase
    end

    assign dw0 = {1'b0, (wd_q ? 2'b10 : 2'b00), 5'b01010, 1'b0, tc_q, 4'b0000,
                  td_q, ep_q, attr_q, 2'b00, (wd_q ? 10'd1 : 10'd0)};
    assign dw1 = {completer_id_i, 3'b000, 1'b0, byte_cnt};
    assign dw2 = {rid_q, tag_q, 1'b0, la_q, lo2};
    // Memory data is little-endian; TLP payload is byte-swapped.
    assign dw3 = {rd_data_i[7:0], rd_data_i[15:8], rd_data_i[23:16], rd_data_i[31:24]};

    always_comb begin
        state_nxt = state;
        td_nxt    = trn_td;
        sof_n_nxt = trn_tsof_n;
        eof_n_nxt = trn_teof_n;
        rdy_n_nxt = trn_tsrc_rdy_n;
        done_nxt  = 1'b0;
        load_req  = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_compl_i) begin
                    load_req  = 1'b1;
                    state_nxt = S_WAIT_BUF;
                end
            end

            S_WAIT_BUF: begin
                if (trn_tbuf_av >= TBUF_MIN_L) begin
                    state_nxt = S_DW0;
                    td_nxt    = dw0;
                    sof_n_nxt = 1'b0;
                    eof_n_nxt = 1'b1;
                    rdy_n_nxt = 1'b0;
                end
            end

            S_DW0, S_DW1, S_DW2, S_DW3: begin
                if (!trn_tdst_dsc_n) begin
                    // Core dropped the frame: restart from DW0 with the same fields.
                    state_nxt = S_WAIT_BUF;
                    sof_n_nxt = 1'b1;
                    eof_n_nxt = 1'b1;
                    rdy_n_nxt = 1'b1;
                end else if (beat_ok) begin
                    case (state)
                        S_DW0: begin
                            state_nxt = S_DW1;
                            td_nxt    = dw1;
                            sof_n_nxt = 1'b1;
                            eof_n_nxt = 1'b1;
                        end
                        S_DW1: begin
                            state_nxt = S_DW2;
                            td_nxt    = dw2;
                            eof_n_nxt = !wd_q ? 1'b0 : 1'b1;
                        end
                        S_DW2: begin
                            if (wd_q) begin
                                state_nxt = S_DW3;
                                td_nxt    = dw3;
                                eof_n_nxt = 1'b0;
                            end else begin
                                state_nxt = S_DONE;
                                eof_n_nxt = 1'b1;
                                rdy_n_nxt = 1'b1;
                                done_nxt  = 1'b1;
                            end
                        end
                        default: begin
                            state_nxt = S_DONE;
                            eof_n_nxt = 1'b1;
                            rdy_n_nxt = 1'b1;
                            done_nxt  = 1'b1;
                        end
                    endcase
                end
            end

            S_DONE: state_nxt = S_IDLE;

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            trn_td         <= '0;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            compl_done_o   <= 1'b0;
            rd_addr_o      <= '0;
            rd_be_o        <= '0;
            wd_q           <= 1'b0;
            tc_q           <= '0;
            td_q           <= 1'b0;
            ep_q           <= 1'b0;
            attr_q         <= '0;
            rid_q          <= '0;
            tag_q          <= '0;
            la_q           <= '0;
        end else begin
            state          <= state_nxt;
            trn_td         <= td_nxt;
            trn_tsof_n     <= sof_n_nxt;
            trn_teof_n     <= eof_n_nxt;
            trn_tsrc_rdy_n <= rdy_n_nxt;
            compl_done_o   <= done_nxt;
            if (load_req) begin
                wd_q      <= req_compl_with_data_i;
                tc_q      <= req_tc_i;
                td_q      <= req_td_i;
                ep_q      <= req_ep_i;
                attr_q    <= req_attr_i;
                rid_q     <= req_rid_i;
                tag_q     <= req_tag_i;
                la_q      <= req_addr_i[6:2];
                rd_addr_o <= ADDR_W'(req_addr_i[12:2]);
                rd_be_o   <= req_be_i[3:0];
            end
        end
    end

endmodule

// File: tb/tb_my_ep_tx_cpl_engine.sv
module tb_my_ep_tx_cpl_engine;
    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              req_compl_i, req_compl_with_data_i;
    logic [2:0]        req_tc_i;
    logic              req_td_i, req_ep_i;
    logic [1:0]        req_attr_i;
    logic [9:0]        req_len_i;
    logic [15:0]       req_rid_i;
    logic [7:0]        req_tag_i, req_be_i;
    logic [12:0]       req_addr_i;
    logic [15:0]       completer_id_i;
    logic              compl_done_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [3:0]        rd_be_o;
    logic [31:0]       rd_data_i;
    logic [31:0]       trn_td;
    logic              trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
    logic              trn_tdst_rdy_n, trn_tdst_dsc_n;
    logic [5:0]        trn_tbuf_av;

    my_ep_tx_cpl_engine #(.ADDR_W(ADDR_W), .TBUF_MIN(1)) dut (
        .clk(clk), .rst(rst),
        .req_compl_i(req_compl_i), .req_compl_with_data_i(req_compl_with_data_i),
        .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i), .req_attr_i(req_attr_i),
        .req_len_i(req_len_i), .req_rid_i(req_rid_i), .req_tag_i(req_tag_i), .req_be_i(req_be_i),
        .req_addr_i(req_addr_i), .completer_id_i(completer_id_i), .compl_done_o(compl_done_o),
        .rd_addr_o(rd_addr_o), .rd_be_o(rd_be_o), .rd_data_i(rd_data_i),
        .trn_td(trn_td), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
        .trn_tdst_dsc_n(trn_tdst_dsc_n), .trn_tbuf_av(trn_tbuf_av)
    );

    // BAR memory, 1-cycle read latency
    logic [31:0] mem [0:2047];
    always @(posedge clk) rd_data_i <= mem[rd_addr_o];

    typedef struct {
        bit          wd;
        logic [2:0]  tc;
        logic        td, ep;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag, be;
        logic [12:0] addr;
    } req_t;

    int n_err = 0, n_chk = 0;
    int done_cnt = 0, done0 = 0, cyc = 0, last_beat_cyc = 0, done_cyc = 0;
    logic [33:0] cap[$];   // {eof_n, sof_n, td} per accepted beat
    logic [33:0] expq[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Beat / done monitor; sampled mid-cycle, where values are stable for the next edge.
    always @(negedge clk) begin
        if (rst) cap.delete();
        else begin
            if (!trn_tdst_dsc_n) cap.delete();
            else if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                cap.push_back({trn_teof_n, trn_tsof_n, trn_td});
                last_beat_cyc = cyc;
            end
            if (compl_done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Reference: TLP as a list of beats, derived from the completion rules.
    task automatic model(input req_t r, input logic [15:0] cid);
        logic [31:0] w [4];
        logic [31:0] d;
        logic [11:0] bc;
        logic [1:0]  lo2;
        int lo, hi, n;
        lo = -1; hi = -1;
        for (int i = 0; i < 4; i++) if (r.be[i]) begin
            if (lo < 0) lo = i;
            hi = i;
        end
        bc  = (!r.wd || lo < 0) ? 12'd1 : 12'(hi - lo + 1);
        lo2 = (lo < 0) ? 2'd0 : 2'(lo);
        d   = mem[r.addr[12:2]];
        w[0] = {1'b0, (r.wd ? 2'b10 : 2'b00), 5'b01010, 1'b0, r.tc, 4'b0000,
                r.td, r.ep, r.attr, 2'b00, (r.wd ? 10'd1 : 10'd0)};
        w[1] = {cid, 3'b000, 1'b0, bc};
        w[2] = {r.rid, r.tag, 1'b0, r.addr[6:2], lo2};
        w[3] = {<<8{d}};
        n = r.wd ? 4 : 3;
        expq.delete();
        for (int i = 0; i < n; i++) expq.push_back({(i != n - 1), (i != 0), w[i]});
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.wd = 1'($urandom_range(0, 1));
        r.tc = 3'($urandom); r.td = 1'($urandom); r.ep = 1'($urandom);
        r.attr = 2'($urandom); r.len = 10'($urandom); r.rid = 16'($urandom);
        r.tag = 8'($urandom); r.be = 8'($urandom); r.addr = 13'($urandom);
        return r;
    endfunction

    task automatic drive_fields(input req_t r);
        req_compl_with_data_i = r.wd;
        req_tc_i = r.tc; req_td_i = r.td; req_ep_i = r.ep; req_attr_i = r.attr;
        req_len_i = r.len; req_rid_i = r.rid; req_tag_i = r.tag;
        req_be_i = r.be; req_addr_i = r.addr;
    endtask

    // Called just after a rising edge, with the DUT idle.
    task automatic start_req(input req_t r);
        cap.delete();
        done0 = done_cnt;
        model(r, completer_id_i);
        drive_fields(r);
        req_compl_i = 1'b1;
        @(posedge clk); #1;
        req_compl_i = 1'b0;
    endtask

    task automatic finish_req(input bit rnd, input string nm);
        bit got = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            req_compl_i = 1'b0;
            if (done_cnt != done0) begin got = 1; break; end
            if (rnd) begin
                trn_tdst_rdy_n = ($urandom_range(0, 2) == 0);
                trn_tbuf_av    = 6'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) begin   // stray request, must be ignored
                    drive_fields(rand_req());
                    req_compl_i = 1'b1;
                end
            end
        end
        trn_tdst_rdy_n = 1'b0;
        trn_tbuf_av    = 6'd4;
        if (!got) chk({nm, ".done_timeout"}, 64'(0), 64'(1));
        else begin
            chk({nm, ".nbeats"}, 64'(cap.size()), 64'(expq.size()));
            for (int i = 0; i < expq.size() && i < cap.size(); i++)
                chk($sformatf("%s.beat%0d", nm, i), 64'(cap[i]), 64'(expq[i]));
            chk({nm, ".done_lat"}, 64'(done_cyc - last_beat_cyc), 64'(1));
            repeat (3) @(posedge clk);
            #1;
            chk({nm, ".done_pulses"}, 64'(done_cnt - done0), 64'(1));
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".src_rdy_n"}, 64'(trn_tsrc_rdy_n), 64'(1));
        chk({nm, ".sof_n"}, 64'(trn_tsof_n), 64'(1));
        chk({nm, ".eof_n"}, 64'(trn_teof_n), 64'(1));
        chk({nm, ".td"}, 64'(trn_td), 64'(0));
        chk({nm, ".done"}, 64'(compl_done_o), 64'(0));
        chk({nm, ".rd_addr"}, 64'(rd_addr_o), 64'(0));
        chk({nm, ".rd_be"}, 64'(rd_be_o), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r1, r;
        rst = 1'b1; req_compl_i = 1'b0; completer_id_i = 16'h0200;
        trn_tdst_rdy_n = 1'b0; trn_tdst_dsc_n = 1'b1; trn_tbuf_av = 6'd4;
        r1 = '{wd: 1'b1, tc: 3'd0, td: 1'b0, ep: 1'b0, attr: 2'd0, len: 10'd1,
               rid: 16'h0100, tag: 8'h05, be: 8'h0F, addr: 13'h0010};
        drive_fields(r1);
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        mem[4] = 32'h12345678;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;

        // CplD and Cpl, core always ready
        start_req(r1); finish_req(0, "cpld");
        r = r1; r.wd = 1'b0;
        start_req(r); finish_req(0, "cpl");

        // Backpressure for 3 cycles while DW1 is presented
        start_req(r1);
        for (int k = 0; k < 50 && cap.size() < 1; k++) begin @(posedge clk); #1; end
        trn_tdst_rdy_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp.hold_td", 64'(trn_td), 64'(32'h02000004));
            chk("bp.src_rdy_n", 64'(trn_tsrc_rdy_n), 64'(0));
        end
        @(posedge clk); #1 trn_tdst_rdy_n = 1'b0;
        finish_req(0, "bp");

        // Byte-count / lower-address corners
        r = r1; r.be = 8'h0C; start_req(r); finish_req(0, "be0c");
        r = r1; r.be = 8'h00; start_req(r); finish_req(0, "be00");
        r = r1; r.be = 8'hF8; start_req(r); finish_req(0, "be8");
        r = r1; r.len = 10'd7; start_req(r); finish_req(0, "len7");

        // No TX buffers at request time
        trn_tbuf_av = 6'd0;
        start_req(r1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("tbuf0.src_rdy_n", 64'(trn_tsrc_rdy_n), 64'(1));
        end
        @(posedge clk); #1 trn_tbuf_av = 6'd4;
        finish_req(0, "tbuf0");

        // Discontinue while DW2 is presented
        start_req(r1);
        for (int k = 0; k < 50 && cap.size() < 2; k++) begin @(posedge clk); #1; end
        trn_tdst_dsc_n = 1'b0;
        @(posedge clk); #1 trn_tdst_dsc_n = 1'b1;
        @(negedge clk);
        chk("dsc.src_rdy_n", 64'(trn_tsrc_rdy_n), 64'(1));
        finish_req(0, "dsc");

        // Reset while DW1 is presented
        start_req(r1);
        for (int k = 0; k < 50 && cap.size() < 1; k++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        repeat (10) @(posedge clk);
        #1;
        chk("midrst.no_done", 64'(done_cnt - done0), 64'(0));
        chk("midrst.no_beats", 64'(cap.size()), 64'(0));

        // Randomized traffic with backpressure, buffer stalls and stray requests
        for (int t = 0; t < 40; t++) begin
            r = rand_req();
            completer_id_i = 16'($urandom);
            if ($urandom_range(0, 3) == 0) trn_tbuf_av = 6'd0;
            start_req(r);
            finish_req(1, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
